// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified memory bus arbiter: FSM state encoding and
// watchdog counter width.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_D = 2'd1,
        ARB_BUSY_I = 2'd2
    } arb_state_e;

    localparam int WDOG_W = 8;

endpackage

// File: rtl/mem_arbiter_slot.sv
// Per-port result slot {done, tag, buf}. Reports a hit when a completed
// result matches the address the core is currently presenting.
module mem_arbiter_slot #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cap,
    input  logic          buf_we,
    input  logic [AW-1:0] cap_addr,
    input  logic [DW-1:0] cap_data,
    input  logic          clr,
    input  logic [AW-1:0] cmp_addr,
    output logic          hit,
    output logic [DW-1:0] buf_data
);

    logic          done_q, done_d;
    logic [AW-1:0] tag_q, tag_d;
    logic [DW-1:0] buf_q, buf_d;

    // A capture outranks the advance clear so a result landing in the same
    // cycle as an advance is still kept.
    always_comb begin
        done_d = done_q;
        tag_d  = tag_q;
        buf_d  = buf_q;
        if (cap) begin
            done_d = 1'b1;
            tag_d  = cap_addr;
            if (buf_we) begin
                buf_d = cap_data;
            end
        end else if (clr) begin
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
            tag_q  <= '0;
            buf_q  <= '0;
        end else begin
            done_q <= done_d;
            tag_q  <= tag_d;
            buf_q  <= buf_d;
        end
    end

    assign hit      = done_q & (tag_q == cmp_addr);
    assign buf_data = buf_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the core's fetch and data ports onto one single-ported bus,
// one transaction at a time, with a per-transaction ack watchdog.
//
// state      | meaning
// ARB_IDLE   | no transaction outstanding; data request wins over fetch
// ARB_BUSY_D | data transaction on the bus, waiting for ack or watchdog
// ARB_BUSY_I | fetch transaction on the bus, waiting for ack or watchdog
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_ren,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic                  rom_stall,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  ram_stall,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_ack,
    output logic                  bus_err
);

    localparam bit WDOG_EN = (TIMEOUT > 0);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_e            state_q, state_d;
    logic                  bus_req_q, bus_req_d;
    logic                  bus_we_q, bus_we_d;
    logic                  bus_err_q, bus_err_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic [WDOG_W-1:0]     wdog_q, wdog_d;

    logic                  hit_i, hit_d, data_req, advance;
    logic                  cap_i, cap_d, abort, buf_we;
    logic [DATA_WIDTH-1:0] cap_data;

    assign data_req  = mem_ren | mem_wen;
    assign rom_stall = ~rst & inst_ren & ~hit_i;
    assign ram_stall = ~rst & data_req & ~hit_d;
    assign advance   = ~rom_stall & ~ram_stall;

    // An aborted transaction yields zero data, which decodes as a NOP fetch.
    assign cap_data = abort ? '0 : bus_rdata;
    assign buf_we   = abort | ~bus_we_q;

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_err_d   = 1'b0;
        wdog_d      = wdog_q;
        cap_i       = 1'b0;
        cap_d       = 1'b0;
        abort       = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (data_req && !hit_d) begin
                    state_d     = ARB_BUSY_D;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_wen;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_dout;
                    wdog_d      = '0;
                end else if (inst_ren && !hit_i) begin
                    state_d    = ARB_BUSY_I;
                    bus_req_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_addr_d = inst_addr;
                    wdog_d     = '0;
                end
            end
            ARB_BUSY_D, ARB_BUSY_I: begin
                if (bus_ack || (WDOG_EN && wdog_q == WDOG_LAST)) begin
                    abort     = ~bus_ack;
                    bus_err_d = ~bus_ack;
                    bus_req_d = 1'b0;
                    state_d   = ARB_IDLE;
                    cap_d     = (state_q == ARB_BUSY_D);
                    cap_i     = (state_q == ARB_BUSY_I);
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_err_q   <= bus_err_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            wdog_q      <= wdog_d;
        end
    end

    mem_arbiter_slot #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_slot_inst (
        .clk      (clk),
        .rst      (rst),
        .cap      (cap_i),
        .buf_we   (buf_we),
        .cap_addr (bus_addr_q),
        .cap_data (cap_data),
        .clr      (advance),
        .cmp_addr (inst_addr),
        .hit      (hit_i),
        .buf_data (inst_data)
    );

    mem_arbiter_slot #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_slot_data (
        .clk      (clk),
        .rst      (rst),
        .cap      (cap_d),
        .buf_we   (buf_we),
        .cap_addr (bus_addr_q),
        .cap_data (cap_data),
        .clr      (advance),
        .cmp_addr (mem_addr),
        .hit      (hit_d),
        .buf_data (mem_din)
    );

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_err   = bus_err_q;

endmodule
